// File: rtl/tx_uart_logic.sv
// Packet assembler for the UART transmit path.
// Frames [CMD][LEN][DATA...][CRC] from a buffer RAM, one byte per transmitter handshake.
module tx_uart_logic #(
    parameter int NUMBER = 256,
    localparam int AW = $clog2(NUMBER)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    cmd_tx,
    input  logic [AW-1:0] len_tx,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_done,
    output logic          busy,
    output logic          pck_sent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RD,
        S_LD
    } state_t;

    typedef enum logic [1:0] {
        P_CMD,
        P_LEN,
        P_DATA,
        P_CRC
    } phase_t;

    localparam logic [AW:0] FULL = (AW+1)'(NUMBER);

    state_t        state_q, state_d;
    phase_t        phase_q;
    logic [AW-1:0] len_q;
    logic [AW:0]   idx_q;
    logic [AW:0]   eff_len;
    logic [7:0]    crc_q;
    logic [7:0]    len_byte;
    logic          more;
    logic          accept;
    logic          done_ok;

    // len 0 stands for a full buffer
    assign eff_len  = (len_q == '0) ? FULL : {1'b0, len_q};
    assign len_byte = 8'(len_q);
    assign more     = idx_q < eff_len;
    assign accept   = (state_q == S_IDLE) && start && !abort;
    assign done_ok  = (state_q == S_WAIT) && tx_done && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (accept) state_d = S_START;
                S_START: state_d = S_WAIT;
                S_WAIT: begin
                    if (tx_done) begin
                        unique case (phase_q)
                            P_CMD:         state_d = S_START;
                            P_LEN, P_DATA: state_d = more ? S_RD : S_START;
                            P_CRC:         state_d = S_IDLE;
                            default:       state_d = S_IDLE;
                        endcase
                    end
                end
                S_RD:    state_d = S_LD;
                S_LD:    state_d = S_START;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_start = (state_q == S_START);
        rd_en    = (state_q == S_RD);
        busy     = (state_q != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= P_CMD;
            len_q    <= '0;
            idx_q    <= '0;
            crc_q    <= '0;
            tx_data  <= '0;
            rd_addr  <= '0;
            pck_sent <= 1'b0;
        end else begin
            pck_sent <= 1'b0;
            if (accept) begin
                phase_q <= P_CMD;
                len_q   <= len_tx;
                idx_q   <= '0;
                crc_q   <= cmd_tx;
                tx_data <= cmd_tx;
            end else if (done_ok) begin
                unique case (phase_q)
                    P_CMD: begin
                        tx_data <= len_byte;
                        crc_q   <= crc_q + len_byte;
                        phase_q <= P_LEN;
                    end
                    P_LEN, P_DATA: begin
                        if (more) begin
                            rd_addr <= idx_q[AW-1:0];
                        end else begin
                            tx_data <= ~crc_q;
                            phase_q <= P_CRC;
                        end
                    end
                    P_CRC:   pck_sent <= 1'b1;
                    default: phase_q <= P_CMD;
                endcase
            end else if (state_q == S_LD && !abort) begin
                tx_data <= rd_data;
                crc_q   <= crc_q + rd_data;
                idx_q   <= idx_q + 1'b1;
                phase_q <= P_DATA;
            end
        end
    end

endmodule

// File: tb/tb_tx_uart_logic.sv
// Bench for tx_uart_logic: RAM and transmitter models, frame reference model,
// randomized packets plus abort, restart and reset cases.
module tb_tx_uart_logic;

    localparam int NUMBER = 256;
    localparam int AW = $clog2(NUMBER);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    cmd_tx = '0;
    logic [AW-1:0] len_tx = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_done;
    logic          busy;
    logic          pck_sent;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [NUMBER];
    logic [7:0] bytes_q [$];
    int         ts_q [$];
    int         td_q [$];
    int         addr_q [$];
    int         cyc = 0;
    int         npck = 0;
    int         stable_err = 0;
    int         tx_delay = 10;
    int         cnt = 0;
    bit         pending = 1'b0;
    logic [7:0] held = '0;

    tx_uart_logic #(.NUMBER(NUMBER)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .cmd_tx   (cmd_tx),
        .len_tx   (len_tx),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_done  (tx_done),
        .busy     (busy),
        .pck_sent (pck_sent)
    );

    always #5 clk = ~clk;

    // synchronous-read buffer RAM
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // byte transmitter model and monitor
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (reset) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                if (tx_data !== held) stable_err++;
                if (cnt == 0) begin
                    tx_done = 1'b1;
                    pending = 1'b0;
                    td_q.push_back(cyc);
                end else begin
                    cnt--;
                end
            end
            if (tx_start) begin
                ts_q.push_back(cyc);
                bytes_q.push_back(tx_data);
                held = tx_data;
                cnt = tx_delay - 1;
                pending = 1'b1;
            end
            if (pck_sent) npck++;
            if (rd_en) addr_q.push_back(int'(rd_addr));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_packet(input logic [7:0] c, input int len,
                               input int dly, input bit poke);
        logic [7:0] exp_q [$];
        int eg [$];
        int n, s, t, acc, b0, s0, d0, a0, p0, e0;
        n = (len == 0) ? NUMBER : len;
        exp_q.push_back(c);
        exp_q.push_back(8'(len));
        s = int'(c) + (len % 256);
        eg.push_back(1);
        eg.push_back(1);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[i]);
            s += int'(mem[i]);
            eg.push_back(3);
        end
        exp_q.push_back(8'(~s));
        eg.push_back(1);
        b0 = bytes_q.size();
        s0 = ts_q.size();
        d0 = td_q.size();
        a0 = addr_q.size();
        p0 = npck;
        e0 = stable_err;
        tx_delay = dly;
        cmd_tx = c;
        len_tx = AW'(len);
        start = 1'b1;
        acc = cyc;
        tick();
        start = 1'b0;
        cmd_tx = 8'($urandom);
        len_tx = AW'($urandom);
        chk("busy_on", 32'(busy), 1);
        t = 0;
        while (npck == p0 && t < 20000) begin
            if (poke && t == 30) begin
                start = 1'b1;
                cmd_tx = 8'h11;
                len_tx = AW'(5);
            end else begin
                start = 1'b0;
            end
            tick();
            t++;
        end
        start = 1'b0;
        chk("timeout", 32'(t < 20000), 1);
        chk("busy_off", 32'(busy), 0);
        repeat (4) tick();
        chk("pck_cnt", 32'(npck - p0), 1);
        chk("stable", 32'(stable_err - e0), 0);
        chk("nbytes", 32'(bytes_q.size() - b0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && b0 + i < bytes_q.size(); i++)
            chk($sformatf("byte%0d", i), 32'(bytes_q[b0+i]), 32'(exp_q[i]));
        if (ts_q.size() > s0)
            chk("gap_start", 32'(ts_q[s0] - acc), 1);
        for (int k = 1; k < eg.size() && s0 + k < ts_q.size()
             && d0 + k - 1 < td_q.size(); k++)
            chk($sformatf("gap%0d", k), 32'(ts_q[s0+k] - td_q[d0+k-1]), 32'(eg[k]));
        chk("naddr", 32'(addr_q.size() - a0), 32'(n));
        for (int i = 0; i < n && a0 + i < addr_q.size(); i++)
            chk($sformatf("addr%0d", i), 32'(addr_q[a0+i]), 32'(i));
    endtask

    initial begin
        int t, b0, p0;
        for (int i = 0; i < NUMBER; i++) mem[i] = 8'($urandom);
        repeat (3) tick();
        chk("rst_txs", 32'(tx_start), 0);
        chk("rst_rden", 32'(rd_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pck", 32'(pck_sent), 0);
        chk("rst_txd", 32'(tx_data), 0);
        chk("rst_addr", 32'(rd_addr), 0);
        reset = 1'b0;
        tick();

        mem[0] = 8'h01;
        mem[1] = 8'h02;
        mem[2] = 8'h03;
        send_packet(8'h5A, 3, 10, 1'b0);

        for (int i = 0; i < NUMBER; i++) mem[i] = 8'(i);
        send_packet(8'h3C, 0, 2, 1'b0);

        mem[0] = 8'hFF;
        send_packet(8'hFF, 1, 50, 1'b0);

        for (int i = 0; i < NUMBER; i++) mem[i] = 8'($urandom);
        send_packet(8'hA7, 4, 10, 1'b1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            send_packet(8'($urandom), $urandom_range(1, 12),
                        $urandom_range(1, 15), 1'b0);
        end

        // abort during the second data byte
        b0 = bytes_q.size();
        p0 = npck;
        tx_delay = 8;
        cmd_tx = 8'h42;
        len_tx = AW'(6);
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (bytes_q.size() < b0 + 4 && t < 2000) begin
            tick();
            t++;
        end
        chk("ab_reach", 32'(bytes_q.size() - b0), 4);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_txs", 32'(tx_start), 0);
        chk("ab_rden", 32'(rd_en), 0);
        repeat (40) tick();
        chk("ab_nobytes", 32'(bytes_q.size() - b0), 4);
        chk("ab_nopck", 32'(npck - p0), 0);
        mem[0] = 8'($urandom);
        send_packet(8'($urandom), 1, 5, 1'b0);

        // start and abort together in idle
        b0 = bytes_q.size();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 0);
        repeat (5) tick();
        chk("sa_nobytes", 32'(bytes_q.size() - b0), 0);

        // asynchronous reset while waiting on the LEN byte
        b0 = bytes_q.size();
        p0 = npck;
        tx_delay = 20;
        cmd_tx = 8'h77;
        len_tx = AW'(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (bytes_q.size() < b0 + 2 && t < 2000) begin
            tick();
            t++;
        end
        chk("rs_reach", 32'(bytes_q.size() - b0), 2);
        repeat (2) tick();
        #2 reset = 1'b1;
        #1;
        chk("rs_txs", 32'(tx_start), 0);
        chk("rs_rden", 32'(rd_en), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_pck", 32'(pck_sent), 0);
        chk("rs_txd", 32'(tx_data), 0);
        chk("rs_addr", 32'(rd_addr), 0);
        tick();
        reset = 1'b0;
        repeat (30) tick();
        chk("rs_nopck", 32'(npck - p0), 0);
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        send_packet(8'($urandom), $urandom_range(1, 8), 3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
